// File: rtl/keccak_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keccak_pad_pkg
// Purpose  : Shared constants, domain-separation byte and FSM state type for
//            the keccak_pad message feeder.
// Config   : KECCAK_PAD_SHA3_EN defined   -> DS = 0x06 (SHA-3 suffix)
//            KECCAK_PAD_SHA3_EN undefined -> DS = 0x01 (Keccak pad10*1)
// Revision : 1.0  initial release
// ============================================================================
package keccak_pad_pkg;

   localparam int N              = 64;                 // core lane/word width
   localparam int RATE_WORDS_DEF = 17;                 // 1088-bit rate
   localparam int BYTES_W_DEF    = $clog2(N / 8) + 1;  // byte-count field width
   localparam int WCNT_W         = 5;                  // holds 0..23

   localparam logic [7:0] DS_KECCAK = 8'h01;
   localparam logic [7:0] DS_SHA3   = 8'h06;

   function automatic logic [7:0] ds_byte(input logic sha3);
      return sha3 ? DS_SHA3 : DS_KECCAK;
   endfunction

`ifdef KECCAK_PAD_SHA3_EN
   localparam logic [7:0] DS = ds_byte(1'b1);
`else
   localparam logic [7:0] DS = ds_byte(1'b0);
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ABSORB = 2'd1,
      PAD    = 2'd2,
      LAST   = 2'd3
   } pad_state_t;

endpackage
`default_nettype wire

// File: rtl/keccak_pad_word.sv
`default_nettype none
// ============================================================================
// Module   : keccak_pad_word
// Purpose  : Combinational byte masker / inserter for one padded word.
//            Bytes below k pass through, byte k becomes ds when ds_en is set,
//            every other byte is zero; final_bit ORs into bit N-1.
// Ports    : data      in  N        raw message word
//            k         in  BYTES_W  number of valid low bytes (N/8 = all)
//            ds_en     in  1        insert ds at byte k
//            ds        in  8        domain-separation byte
//            final_bit in  1        set bit N-1 (closing pad bit)
//            padded    out N        resulting word
// Revision : 1.0  initial release
// ============================================================================
module keccak_pad_word
   import keccak_pad_pkg::*;
#(
   parameter int BYTES_W = BYTES_W_DEF
) (
   input  logic [N-1:0]       data,
   input  logic [BYTES_W-1:0] k,
   input  logic               ds_en,
   input  logic [7:0]         ds,
   input  logic               final_bit,
   output logic [N-1:0]       padded
);

   always_comb begin
      padded = '0;
      for (int i = 0; i < N / 8; i++) begin
         if (BYTES_W'(i) < k)
            padded[8*i +: 8] = data[8*i +: 8];
         else if ((BYTES_W'(i) == k) && ds_en)
            padded[8*i +: 8] = ds;
      end
      // The closing bit may share a byte with ds (ds|0x80 in one byte).
      padded[N-1] = padded[N-1] | final_bit;
   end

endmodule
`default_nettype wire

// File: rtl/keccak_pad.sv
`default_nettype none
// ============================================================================
// Module   : keccak_pad
// Purpose  : Upstream feeder for the keccak core. Applies multi-rate padding
//            to a byte-granular word stream and cuts it into RATE_WORDS-word
//            blocks. One message in flight at a time.
// Config   : KECCAK_PAD_SHA3_EN selects the SHA-3 domain byte (see package).
// Ports    : Clock, Reset (sync, active high)
//            Msg_data/Msg_bytes/Msg_valid/Msg_last  in   message stream
//            Msg_ready                              out  word accepted
//            Start       out  one-cycle message-start pulse to core
//            Din         out  padded word to core
//            Din_valid   out  Din transferred this cycle
//            Last_block  out  pulse after final block fully written
//            Buffer_full in   core buffer full, stalls transfers
//            Ready       in   core idle, may begin a new message
// Revision : 1.0  initial release
// ============================================================================
module keccak_pad
   import keccak_pad_pkg::*;
#(
   parameter int RATE_WORDS = RATE_WORDS_DEF,
   parameter int BYTES_W    = BYTES_W_DEF
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [N-1:0]       Msg_data,
   input  logic [BYTES_W-1:0] Msg_bytes,
   input  logic               Msg_valid,
   input  logic               Msg_last,
   output logic               Msg_ready,
   output logic               Start,
   output logic [N-1:0]       Din,
   output logic               Din_valid,
   output logic               Last_block,
   input  logic               Buffer_full,
   input  logic               Ready
);

   localparam logic [BYTES_W-1:0] FULL_K   = BYTES_W'(N / 8);
   localparam logic [WCNT_W-1:0]  WCNT_MAX = WCNT_W'(RATE_WORDS - 1);

   pad_state_t          state, state_nxt;
   logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
   logic                pend_ds, pend_ds_nxt;   // full last word: DS still owed

   logic                at_end;
   logic                short_last;
   logic [N-1:0]        word_data;
   logic [BYTES_W-1:0]  word_k;
   logic                word_ds_en;
   logic                word_final;

   assign at_end     = (wcnt == WCNT_MAX);
   assign short_last = Msg_last && (Msg_bytes < FULL_K);

   keccak_pad_word #(
      .BYTES_W   (BYTES_W)
   ) u_word (
      .data      (word_data),
      .k         (word_k),
      .ds_en     (word_ds_en),
      .ds        (DS),
      .final_bit (word_final),
      .padded    (Din)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         wcnt    <= '0;
         pend_ds <= 1'b0;
      end else begin
         state   <= state_nxt;
         wcnt    <= wcnt_nxt;
         pend_ds <= pend_ds_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wcnt_nxt    = wcnt;
      pend_ds_nxt = pend_ds;
      Start       = 1'b0;
      Msg_ready   = 1'b0;
      Din_valid   = 1'b0;
      Last_block  = 1'b0;
      word_data   = '0;
      word_k      = '0;
      word_ds_en  = 1'b0;
      word_final  = 1'b0;

      case (state)
         IDLE: begin
            // Gated by Reset so Start stays low while reset is held.
            if (Msg_valid && Ready && !Reset) begin
               Start       = 1'b1;
               state_nxt   = ABSORB;
               wcnt_nxt    = '0;
               pend_ds_nxt = 1'b0;
            end
         end

         ABSORB: begin
            Msg_ready  = !Buffer_full;
            Din_valid  = Msg_valid && !Buffer_full;
            word_data  = Msg_data;
            // Non-last words pass whole; with k = N/8 no byte index matches
            // k, so ds_en may simply follow Msg_last.
            word_k     = Msg_last ? Msg_bytes : FULL_K;
            word_ds_en = Msg_last;
            word_final = short_last && at_end;
            if (Din_valid) begin
               wcnt_nxt = at_end ? '0 : wcnt + 1'b1;
               if (Msg_last) begin
                  if (short_last && at_end) begin
                     state_nxt = LAST;
                  end else begin
                     state_nxt   = PAD;
                     pend_ds_nxt = !short_last;
                  end
               end
            end
         end

         PAD: begin
            Din_valid  = !Buffer_full;
            word_ds_en = pend_ds;
            word_final = at_end;
            if (Din_valid) begin
               pend_ds_nxt = 1'b0;
               wcnt_nxt    = at_end ? '0 : wcnt + 1'b1;
               if (at_end)
                  state_nxt = LAST;
            end
         end

         LAST: begin
            Last_block = 1'b1;
            state_nxt  = IDLE;
            wcnt_nxt   = '0;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifndef SYNTHESIS
   always_ff @(posedge Clock) begin
      if (!Reset && (state == ABSORB) && Msg_valid)
         assert ((Msg_bytes <= FULL_K) && (Msg_last || (Msg_bytes == FULL_K)))
            else $error("keccak_pad: illegal Msg_bytes %0d", Msg_bytes);
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_keccak_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_pad
// Purpose  : Self-checking bench for keccak_pad. Expected words come from a
//            byte-level padding model (append DS, zero-fill to the rate,
//            OR 0x80 into the final byte).
// Revision : 1.0  initial release
// ============================================================================
module tb_keccak_pad;

   localparam int W  = 64;
   localparam int R  = 17;
   localparam int BW = 4;
`ifdef KECCAK_PAD_SHA3_EN
   localparam logic [7:0] DS_TB = 8'h06;
`else
   localparam logic [7:0] DS_TB = 8'h01;
`endif

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic [W-1:0]  Msg_data = '0;
   logic [BW-1:0] Msg_bytes = '0;
   logic          Msg_valid = 1'b0;
   logic          Msg_last = 1'b0;
   logic          Msg_ready;
   logic          Start;
   logic [W-1:0]  Din;
   logic          Din_valid;
   logic          Last_block;
   logic          Buffer_full = 1'b0;
   logic          Ready = 1'b1;

   keccak_pad #(.RATE_WORDS(R)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Msg_data    (Msg_data),
      .Msg_bytes   (Msg_bytes),
      .Msg_valid   (Msg_valid),
      .Msg_last    (Msg_last),
      .Msg_ready   (Msg_ready),
      .Start       (Start),
      .Din         (Din),
      .Din_valid   (Din_valid),
      .Last_block  (Last_block),
      .Buffer_full (Buffer_full),
      .Ready       (Ready)
   );

   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] msg_w[$];
   int           msg_k;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got[$];
   int           start_cnt, last_cnt, bf_viol, din_unstable;
   int           bf_pct = 0;
   bit           timed_out;
   bit           active = 0, stall_pending = 0;
   logic [W-1:0] stall_din;

   // Monitor: outputs sampled on the falling edge.
   initial begin
      forever begin
         @(negedge Clock);
         if (Reset) begin
            active = 0;
            stall_pending = 0;
         end else begin
            if (Din_valid) got.push_back(Din);
            if (Start) start_cnt++;
            if (Last_block) last_cnt++;
            if (Buffer_full && Din_valid) bf_viol++;
            if (active && !Start && !Last_block) begin
               if (Buffer_full) begin
                  if (stall_pending && Din !== stall_din) din_unstable++;
                  stall_pending = 1;
                  stall_din = Din;
               end else if (Din_valid) begin
                  if (stall_pending && Din !== stall_din) din_unstable++;
                  stall_pending = 0;
               end
            end
            if (Start) active = 1;
            if (Last_block) begin
               active = 0;
               stall_pending = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: pad the message as a byte string, then repack into words.
   function automatic void model();
      byte unsigned b[$];
      int total, padlen;
      exp_q.delete();
      for (int w = 0; w < msg_w.size(); w++) begin
         int nb;
         nb = (w == msg_w.size() - 1) ? msg_k : 8;
         for (int i = 0; i < nb; i++) b.push_back(msg_w[w][8*i +: 8]);
      end
      total  = b.size();
      padlen = R * 8 - (total % (R * 8));
      for (int i = 0; i < padlen; i++) b.push_back(8'h00);
      b[total] = b[total] | DS_TB;
      b[b.size() - 1] = b[b.size() - 1] | 8'h80;
      for (int w = 0; w < b.size() / 8; w++) begin
         logic [W-1:0] x;
         for (int i = 0; i < 8; i++) x[8*i +: 8] = b[8*w + i];
         exp_q.push_back(x);
      end
   endfunction

   function automatic void make_msg(input int nwords, input int k);
      msg_w.delete();
      for (int i = 0; i < nwords; i++) msg_w.push_back({$urandom, $urandom});
      msg_k = k;
   endfunction

   task automatic drive_word(input int idx);
      Msg_data  = msg_w[idx];
      Msg_last  = (idx == msg_w.size() - 1);
      Msg_bytes = Msg_last ? BW'(msg_k) : BW'(8);
   endtask

   // Offers the message; abort_at >= 0 asserts Reset once that many words
   // have been accepted and returns immediately.
   task automatic send_msg(input int abort_at);
      int idx, cyc;
      bit acc;
      idx = 0; cyc = 0;
      got.delete();
      start_cnt = 0; last_cnt = 0; bf_viol = 0; din_unstable = 0;
      timed_out = 0;
      @(posedge Clock); #1;
      Msg_valid = 1;
      drive_word(0);
      Buffer_full = ($urandom_range(99) < bf_pct);
      while (idx < msg_w.size() && cyc < 3000) begin
         @(negedge Clock);
         acc = Msg_ready;
         @(posedge Clock); #1;
         cyc++;
         if (acc) idx++;
         if (abort_at >= 0 && idx == abort_at) begin
            Reset = 1; Msg_valid = 0; Msg_last = 0; Buffer_full = 0;
            return;
         end
         if (idx < msg_w.size()) drive_word(idx);
         else begin Msg_valid = 0; Msg_last = 0; end
         Buffer_full = ($urandom_range(99) < bf_pct);
      end
      while (last_cnt == 0 && cyc < 3000) begin
         @(posedge Clock); #1;
         cyc++;
         Buffer_full = ($urandom_range(99) < bf_pct);
      end
      Buffer_full = 0;
      @(posedge Clock); #1;
      timed_out = (cyc >= 3000);
   endtask

   task automatic test_reset();
      Reset = 1; Msg_valid = 1; Ready = 1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      checks++;
      if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", Start); end
      #1; Msg_valid = 0;
      @(posedge Clock); #1; Reset = 0;
      @(negedge Clock);
      checks++;
      if (Msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready: got %b want 0", Msg_ready); end
      checks++;
      if (Din_valid !== 1'b0) begin errors++; $display("FAIL reset_din_valid: got %b want 0", Din_valid); end
      checks++;
      if (Last_block !== 1'b0) begin errors++; $display("FAIL reset_last_block: got %b want 0", Last_block); end
      checks++;
      if (Din !== '0) begin errors++; $display("FAIL reset_din: got %h want 0", Din); end
      // Core not ready: a pending message must not start.
      #1; Ready = 0; Msg_valid = 1;
      repeat (3) begin
         @(negedge Clock);
         checks++;
         if (Start !== 1'b0) begin errors++; $display("FAIL notready_start: got %b want 0", Start); end
      end
      #1; Msg_valid = 0; Ready = 1;
      @(posedge Clock); #1;
   endtask

   task automatic test_empty();
      bf_pct = 0;
      make_msg(1, 0);
      model();
      send_msg(-1);
      checks++;
      if (timed_out) begin errors++; $display("FAIL empty_timeout: got timeout want completion"); end
      checks++;
      if (got.size() !== R) begin errors++; $display("FAIL empty_len: got %0d want %0d", got.size(), R); end
      if (got.size() == R) begin
         checks++;
         if (got[0] !== {56'h0, DS_TB}) begin errors++; $display("FAIL empty_word0: got %h want %h", got[0], {56'h0, DS_TB}); end
         checks++;
         if (got[R-1] !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL empty_word16: got %h want 8000000000000000", got[R-1]); end
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL empty_w%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (start_cnt !== 1 || last_cnt !== 1) begin errors++; $display("FAIL empty_pulses: got start=%0d last=%0d want 1/1", start_cnt, last_cnt); end
   endtask

   task automatic test_abc();
      bf_pct = 0;
      make_msg(1, 3);
      msg_w[0] = 64'hDEAD_BEEF_FF63_6261;   // junk above byte 2 must be masked
      model();
      send_msg(-1);
      checks++;
      if (got.size() !== R) begin errors++; $display("FAIL abc_len: got %0d want %0d", got.size(), R); end
      if (got.size() > 0) begin
         checks++;
         if (got[0] !== {40'h0, DS_TB, 24'h636261}) begin errors++; $display("FAIL abc_word0: got %h want %h", got[0], {40'h0, DS_TB, 24'h636261}); end
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL abc_w%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (last_cnt !== 1) begin errors++; $display("FAIL abc_last: got %0d want 1", last_cnt); end
   endtask

   task automatic test_full_block();
      bf_pct = 0;
      make_msg(R, 8);
      model();
      send_msg(-1);
      checks++;
      if (got.size() !== 2 * R) begin errors++; $display("FAIL full_len: got %0d want %0d", got.size(), 2 * R); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_w%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (last_cnt !== 1) begin errors++; $display("FAIL full_last: got %0d want 1", last_cnt); end
   endtask

   task automatic test_boundary_k7();
      bf_pct = 0;
      make_msg(R, 7);
      model();
      send_msg(-1);
      checks++;
      if (got.size() !== R) begin errors++; $display("FAIL k7_len: got %0d want %0d", got.size(), R); end
      if (got.size() == R) begin
         checks++;
         if (got[R-1][63:56] !== (DS_TB | 8'h80)) begin errors++; $display("FAIL k7_byte7: got %h want %h", got[R-1][63:56], DS_TB | 8'h80); end
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL k7_w%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_stall();
      bf_pct = 50;
      make_msg(40, $urandom_range(8));
      model();
      send_msg(-1);
      bf_pct = 0;
      checks++;
      if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout want completion"); end
      checks++;
      if (got.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_w%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (bf_viol !== 0) begin errors++; $display("FAIL stall_xfer_when_full: got %0d want 0", bf_viol); end
      checks++;
      if (din_unstable !== 0) begin errors++; $display("FAIL stall_din_stable: got %0d changes want 0", din_unstable); end
      checks++;
      if (last_cnt !== 1) begin errors++; $display("FAIL stall_last: got %0d want 1", last_cnt); end
   endtask

   task automatic test_random();
      for (int m = 0; m < 8; m++) begin
         bf_pct = 25;
         make_msg($urandom_range(1, 40), $urandom_range(8));
         model();
         send_msg(-1);
         bf_pct = 0;
         checks++;
         if (got.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", m, got.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_w%0d: got %h want %h", m, i, got[i], exp_q[i]); end
         end
         checks++;
         if (start_cnt !== 1 || last_cnt !== 1 || bf_viol !== 0) begin
            errors++;
            $display("FAIL rand%0d_ctl: got start=%0d last=%0d viol=%0d want 1/1/0", m, start_cnt, last_cnt, bf_viol);
         end
      end
   endtask

   task automatic test_reset_mid();
      bf_pct = 0;
      make_msg(12, 8);
      send_msg(5);
      @(posedge Clock); #1;
      Reset = 0;
      @(negedge Clock);
      checks++;
      if ({Start, Din_valid, Msg_ready, Last_block} !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_ctl: got %b want 0000", {Start, Din_valid, Msg_ready, Last_block});
      end
      checks++;
      if (Din !== '0) begin errors++; $display("FAIL midreset_din: got %h want 0", Din); end
      checks++;
      if (last_cnt !== 0) begin errors++; $display("FAIL midreset_last: got %0d want 0", last_cnt); end
      // Fresh message must begin at word count 0.
      make_msg(3, 5);
      model();
      send_msg(-1);
      checks++;
      if (got.size() !== exp_q.size()) begin errors++; $display("FAIL after_reset_len: got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL after_reset_w%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (start_cnt !== 1 || last_cnt !== 1) begin errors++; $display("FAIL after_reset_pulses: got start=%0d last=%0d want 1/1", start_cnt, last_cnt); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_abc();
      test_full_block();
      test_boundary_k7();
      test_stall();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keccak_pad.md
Name: keccak_pad

Overview:
Upstream feeder for the keccak core. Accepts a byte-granular message stream of N-bit words, applies Keccak multi-rate padding, and segments the result into RATE_WORDS-word blocks. It drives Start/Din/Din_valid/Last_block into keccak and honours its Buffer_full/Ready flow control. One message is in flight at a time.

Parameters:
RATE_WORDS, 17, N-bit words per rate block (1088-bit rate for N=64); legal range 2..24
BYTES_W, $clog2(N/8)+1, width of the byte-count field (4 for N=64)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Msg_data  in  N  message word; byte i is bits [8i+7:8i] (little-endian lanes)
Msg_bytes  in  BYTES_W  valid bytes in Msg_data (low bytes); must be N/8 unless Msg_last; 0..N/8 on last
Msg_valid  in  1  message word offered
Msg_last  in  1  word is final message word
Msg_ready  out  1  word accepted when Msg_valid && Msg_ready
Start  out  1  one-cycle pulse to core at message start
Din  out  N  padded word to core
Din_valid  out  1  Din transferred this cycle
Last_block  out  1  one-cycle pulse after final block fully written
Buffer_full  in  1  core input buffer full; no transfer while high
Ready  in  1  core idle and able to begin a new message

Behaviour:
- Reset: state IDLE, word counter 0; Start, Din_valid, Last_block, Msg_ready = 0; Din = 0.
- Registered state and word counter wcnt (0..RATE_WORDS-1). Outputs are combinational from state, wcnt and inputs (zero latency in ABSORB).
- IDLE: when Msg_valid && Ready -> Start=1 for one cycle, go ABSORB. No word is consumed in the Start cycle.
- ABSORB: Msg_ready = !Buffer_full; Din_valid = Msg_valid && !Buffer_full. A transfer increments wcnt, wrapping at RATE_WORDS-1 -> 0.
  - Non-last word: Din = Msg_data.
  - Last word with Msg_bytes=k<N/8: bytes >=k zeroed, byte k = DS (0x01). If wcnt=RATE_WORDS-1, bit N-1 is also set; the last block is complete and the block goes to LAST. Otherwise go PAD.
  - Last word with k=N/8: Din = Msg_data, go PAD with pending-DS flag set.
  - Last word with k=0: Din = DS in byte 0, with the same wcnt rules as k<N/8.
- PAD: Msg_ready=0; Din_valid = !Buffer_full. Din = 0, with byte 0 = DS if the pending-DS flag is set (flag cleared on transfer), and bit N-1 set when wcnt=RATE_WORDS-1. The transfer at wcnt=RATE_WORDS-1 goes to LAST. Pending-DS at wcnt=RATE_WORDS-1 yields DS|0x80 in one word.
- LAST: Last_block=1 for one cycle with Din_valid=0, then IDLE. It does not wait on Buffer_full.
- A full final block (last word at wcnt=RATE_WORDS-1 with k=N/8) produces an entire extra block of padding.
- Buffer_full high stalls every transfer; Din holds its value.
- Reset mid-message aborts to IDLE immediately with no Last_block. The core shares Reset.
- Msg_bytes>N/8, or <N/8 on a non-last word, is illegal; the result is undefined (assertion in simulation).

Optional Feature:
KECCAK_PAD_SHA3_EN: when defined, DS = 0x06 (FIPS-202 SHA-3 domain separation). When undefined, DS = 0x01 (original Keccak pad10*1). The 0x80 final-bit rule is unchanged in both cases.

Decomposition:
- pkg_keccak gains RATE_WORDS default, the DS_KECCAK/DS_SHA3 byte constants, and an enum for pad_state_t {IDLE, ABSORB, PAD, LAST}. N is reused from pkg_keccak.
- One natural sub-module, keccak_pad_word: combinational byte masker/inserter (data, k, ds_en, final_bit -> padded word). The FSM stays in keccak_pad.

Test Plan:
- Empty message (one word, Msg_last, Msg_bytes=0), RATE_WORDS=17 -> Start; 17 Din words: word0=0x01, words1-15=0, word16=0x8000_0000_0000_0000; then Last_block pulse.
- 3-byte message 0x636261 -> word0=0x0000_0000_0163_6261, zeros, word16 bit63 set; with KECCAK_PAD_SHA3_EN, word0=0x0000_0000_0663_6261.
- 17 full words (136 bytes) -> 17 words pass unchanged, then a second block: word0=0x01, word16=0x80<<56. Total 34 Din_valid, one Last_block.
- 16 full words + last with Msg_bytes=8 -> 17 words unmodified, then a full padding block. Separately, 16 full + last k=7 -> word16 has byte7=0x81.
- Buffer_full toggled randomly during a 40-word message -> no transfer while high, Din stable, word order and padding identical to the unstalled run.
- Reset asserted at word 5 -> next cycle all outputs 0 and state IDLE; the following message begins with a fresh Start and wcnt=0.
